// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Command/result handshake bundle connecting a requester to alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, illegal
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, result_hi, zero, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU; 1-cycle logic ops, iterative shift-add multiply
//               and restoring divide. Divider built only when ALU_SEQ_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             is_mul;
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (bus.op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_NOT:  alu_res = ~bus.a;
      OP_SLL:  alu_res = bus.a << bus.shamt;
      OP_SRL:  alu_res = bus.a >> bus.shamt;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SRA:  alu_res = $signed(bus.a) >>> bus.shamt;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_MULU: is_mul  = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIVU: is_div  = 1'b1;
`else
      OP_DIVU: alu_ill = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration: {hi,lo} is the multiply accumulator or the remainder/quotient pair
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opd_q});
    div_diff  = div_shift[WIDTH-1:0] - opd_q;
    if (div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opd_d       = opd_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
`ifdef ALU_SEQ_DIV_EN
    div_d       = div_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_mul || is_div) begin
            state_d = BUSY;
            cnt_d   = '0;
            hi_d    = '0;
            // multiply walks the multiplier b; divide walks the dividend a
            lo_d    = is_mul ? bus.b : bus.a;
            opd_d   = is_mul ? bus.a : bus.b;
`ifdef ALU_SEQ_DIV_EN
            div_d   = is_div;
`endif
          end else begin
            state_d     = DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = DONE;
          cnt_d       = '0;
          result_d    = step_lo;
          result_hi_d = step_hi;
          zero_d      = (step_lo == '0);
          illegal_d   = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opd_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opd_q       <= opd_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_SEQ_DIV_EN
      div_q       <= div_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand/result width (legal 8..64).
REQ-002 Parameter SHW, default 5, SHALL set shift-amount width; SHW = clog2(WIDTH).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active low.
REQ-005 in_valid  input  1  command valid.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 op  input  4  operation code (REQ-013).
REQ-008 a  input  WIDTH  operand 1.
REQ-009 b  input  WIDTH  operand 2.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result valid; out_ready  input  1  consumer accepts.
REQ-012 result  output  WIDTH  low/primary result; result_hi  output  WIDTH  high product or remainder; zero  output  1  result==0; illegal  output  1  unsupported op.

Function
REQ-013 Opcodes SHALL be: 0 add, 1 sub, 2 not a, 3 sll a by shamt, 4 srl a by shamt, 5 and, 6 or, 7 sltu (1/0), 8 slt signed, 9 sra a by shamt, 10 xor, 11 nor, 12 mulu, 13 divu, 14-15 illegal.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Handshake: command accepted on rising edge with in_valid & in_ready; a, b, op, shamt SHALL be captured then and later input changes ignored.
REQ-016 Single-cycle ops (0-11, illegal): IDLE -> DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-017 mulu: IDLE -> BUSY; shift-add, one bit per cycle, WIDTH iterations; then DONE; {result_hi,result} = full 2*WIDTH unsigned product; latency WIDTH+1.
REQ-018 divu: restoring divide, WIDTH iterations, same latency as mulu; result = quotient, result_hi = remainder.
REQ-019 Divide by zero SHALL give result all ones, result_hi = a, illegal = 0, latency unchanged.
REQ-020 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-021 Non-mul/div ops SHALL drive result_hi = 0.
REQ-022 Illegal ops SHALL give result 0, result_hi 0, illegal 1, zero 1.
REQ-023 zero SHALL reflect result only (not result_hi).
REQ-024 In DONE, out_valid and all result outputs SHALL hold stable until out_valid & out_ready, then return to IDLE next edge.
REQ-025 No new command SHALL be accepted in the cycle DONE is left (no bypass); max throughput one op per 2 cycles.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs except none.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, out_valid 0, result 0, result_hi 0, zero 0, illegal 0, iteration counter 0.
REQ-028 Reset mid-BUSY or mid-DONE SHALL abort the op with no result ever presented.
REQ-029 in_ready SHALL be 1 from the first edge after rst_n deasserts.

Configuration
REQ-030 Macro ALU_SEQ_DIV_EN defined: divu as REQ-018/019.
REQ-031 ALU_SEQ_DIV_EN undefined: no divider logic; op 13 treated as illegal per REQ-022 with latency 1.

Verification
REQ-032 Reset, WIDTH=32, add a=0xFFFFFFFF b=1 -> out_valid after 1 cycle, result 0, zero 1, result_hi 0.
REQ-033 mulu a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid after 33 cycles, result 0x00000001, result_hi 0xFFFFFFFE.
REQ-034 divu a=100 b=7 -> result 14, result_hi 2; divu a=5 b=0 -> result 0xFFFFFFFF, result_hi 5; without ALU_SEQ_DIV_EN op 13 -> illegal 1 after 1 cycle.
REQ-035 slt a=0xFFFFFFFF b=1 -> 1; sltu same -> 0; sra a=0x80000000 shamt 4 -> 0xF8000000.
REQ-036 Backpressure: out_ready held 0 for 5 cycles after sub 3-5 -> result 0xFFFFFFFE stable, in_ready 0 throughout; inputs changed meanwhile ignored.
REQ-037 rst_n pulsed low at BUSY cycle 10 of mulu -> outputs zero at once, no out_valid, next add 2+3 -> 5.
